fc_feed_sched: RTL and testbench



---
 rtl/fc_pkg.sv | 28 ++
 rtl/fc_addr_gen.sv | 60 ++++++
 rtl/fc_feed_sched.sv | 183 ++++++++++++++++++
 tb/tb_fc_feed_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared widths, FSM encoding and lane helper for the fully-connected feed scheduler.
// Timing and flow control belong to the modules that import this package.
package fc_pkg;
  localparam int DW      = 32;
  localparam int WORD_W  = 256;
  localparam int LEN_W   = 12;
  localparam int FIN_AW  = 11;
  localparam int WGT_AW  = 24;
  localparam int BIAS_AW = 9;
  localparam int LANE_N  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REQ,
    ST_PRIME,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Lane idx of one 4-lane half: half 0 is word[127:0], half 1 is word[255:128].
  function automatic logic [DW-1:0] word_lane(input logic [WORD_W-1:0] word,
                                              input logic half, input logic [1:0] idx);
    logic [7:0] lsb;
    lsb = {half, idx, 5'd0};
    return word[lsb +: DW];
  endfunction
endpackage

// File: rtl/fc_addr_gen.sv
// Read pointer over (channel o, word w) in issue order; the weight address simply increments.
// Updates one cycle after step_i; no backpressure, the caller paces the steps.
module fc_addr_gen
  import fc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic              step_i,
  input  logic [FIN_AW-1:0] wpo_i,
  input  logic [LEN_W-1:0]  fout_len_i,
  input  logic [WGT_AW-1:0] wgt_base_i,
  output logic [FIN_AW-1:0] w_o,
  output logic [LEN_W-1:0]  o_o,
  output logic [WGT_AW-1:0] wgt_addr_o,
  output logic              last_w_o,
  output logic              last_o_o
);
  logic [FIN_AW-1:0] w_q, w_d;
  logic [LEN_W-1:0]  o_q, o_d;
  logic [WGT_AW-1:0] wa_q, wa_d;

  assign w_o        = w_q;
  assign o_o        = o_q;
  assign wgt_addr_o = wa_q;
  assign last_w_o   = (w_q == wpo_i - FIN_AW'(1));
  assign last_o_o   = (o_q == fout_len_i - LEN_W'(1));

  always_comb begin
    w_d  = w_q;
    o_d  = o_q;
    wa_d = wa_q;
    if (init_i) begin
      w_d  = '0;
      o_d  = '0;
      wa_d = wgt_base_i;
    end else if (step_i) begin
      // Words of consecutive channels are contiguous, so base + o*Wpo + w is a plain increment.
      wa_d = wa_q + WGT_AW'(1);
      if (last_w_o) begin
        w_d = '0;
        o_d = o_q + LEN_W'(1);
      end else begin
        w_d = w_q + FIN_AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q  <= '0;
      o_q  <= '0;
      wa_q <= '0;
    end else begin
      w_q  <= w_d;
      o_q  <= o_d;
      wa_q <= wa_d;
    end
  end
endmodule

// File: rtl/fc_feed_sched.sv
// Sequences one FC layer: RAM words split into two 4-lane halves, one half per cycle.
// Feed starts 3 cycles after mac_req is sampled in WAIT_REQ; done follows the last fc_fout_vld.
module fc_feed_sched
  import fc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [LEN_W-1:0]   cfg_fin_div4_len,
  input  logic [LEN_W-1:0]   cfg_fout_len,
  input  logic [WGT_AW-1:0]  cfg_wgt_base,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  input  logic               mac_req,
  input  logic               fc_fout_vld,
  output logic               fin_rd_en,
  output logic [FIN_AW-1:0]  fin_rd_addr,
  input  logic [WORD_W-1:0]  fin_rd_data,
  output logic               wgt_rd_en,
  output logic [WGT_AW-1:0]  wgt_rd_addr,
  input  logic [WORD_W-1:0]  wgt_rd_data,
  output logic               bias_rd_en,
  output logic [BIAS_AW-1:0] bias_rd_addr,
  input  logic [WORD_W-1:0]  bias_rd_data,
  output logic               fc_calc_ing,
  output logic [DW-1:0]      fc_fin_0,
  output logic [DW-1:0]      fc_fin_1,
  output logic [DW-1:0]      fc_fin_2,
  output logic [DW-1:0]      fc_fin_3,
  output logic [DW-1:0]      fc_wgt_0,
  output logic [DW-1:0]      fc_wgt_1,
  output logic [DW-1:0]      fc_wgt_2,
  output logic [DW-1:0]      fc_wgt_3,
  output logic [DW-1:0]      fc_bias
);
  state_e            state_q, state_d;
  logic [FIN_AW-1:0] wpo_q, wpo_d;
  logic [LEN_W-1:0]  fout_len_q, fout_len_d, vld_cnt_q, vld_cnt_d;
  logic              half_q, half_d, rd_q, rd_d, brd_q, brd_d, rd_all_q, rd_all_d, err_q, err_d;
  logic [2:0]        bsel_q, bsel_d;
  logic [WORD_W-1:0] fin_buf_q, fin_buf_d, wgt_buf_q, wgt_buf_d;
  logic [DW-1:0]     bias_q, bias_d;

  logic              cfg_legal, init, issue, in_layer;
  logic [FIN_AW-1:0] ag_w;
  logic [LEN_W-1:0]  ag_o;
  logic [WGT_AW-1:0] ag_wa;
  logic              ag_last_w, ag_last_o;

  assign cfg_legal = !cfg_fin_div4_len[0] && (cfg_fin_div4_len != '0) && (cfg_fout_len != '0);
  assign init      = (state_q == ST_IDLE) && cfg_start && cfg_legal;
  assign issue     = (state_q == ST_PRIME) || ((state_q == ST_RUN) && !half_q && !rd_all_q);
  assign in_layer  = (state_q != ST_IDLE) && (state_q != ST_WAIT_REQ);

  fc_addr_gen u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_i     (init),
    .step_i     (issue),
    .wpo_i      (wpo_q),
    .fout_len_i (fout_len_q),
    .wgt_base_i (cfg_wgt_base),
    .w_o        (ag_w),
    .o_o        (ag_o),
    .wgt_addr_o (ag_wa),
    .last_w_o   (ag_last_w),
    .last_o_o   (ag_last_o)
  );

  assign fin_rd_en    = issue;
  assign wgt_rd_en    = issue;
  assign bias_rd_en   = issue && (ag_w == '0);
  assign fin_rd_addr  = ag_w;
  assign wgt_rd_addr  = ag_wa;
  assign bias_rd_addr = ag_o[LEN_W-1:3];

  assign busy        = (state_q != ST_IDLE);
  assign cfg_err     = err_q;
  assign fc_calc_ing = (state_q == ST_RUN);
  assign fc_bias     = bias_q;
  assign fc_fin_0    = word_lane(fin_buf_q, half_q, 2'd0);
  assign fc_fin_1    = word_lane(fin_buf_q, half_q, 2'd1);
  assign fc_fin_2    = word_lane(fin_buf_q, half_q, 2'd2);
  assign fc_fin_3    = word_lane(fin_buf_q, half_q, 2'd3);
  assign fc_wgt_0    = word_lane(wgt_buf_q, half_q, 2'd0);
  assign fc_wgt_1    = word_lane(wgt_buf_q, half_q, 2'd1);
  assign fc_wgt_2    = word_lane(wgt_buf_q, half_q, 2'd2);
  assign fc_wgt_3    = word_lane(wgt_buf_q, half_q, 2'd3);

  always_comb begin
    state_d    = state_q;
    wpo_d      = wpo_q;
    fout_len_d = fout_len_q;
    vld_cnt_d  = vld_cnt_q;
    half_d     = 1'b0;
    rd_all_d   = rd_all_q;
    err_d      = 1'b0;
    bsel_d     = bsel_q;
    fin_buf_d  = fin_buf_q;
    wgt_buf_d  = wgt_buf_q;
    bias_d     = bias_q;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_legal) begin
            wpo_d      = cfg_fin_div4_len[LEN_W-1:1];
            fout_len_d = cfg_fout_len;
            vld_cnt_d  = '0;
            rd_all_d   = 1'b0;
            state_d    = ST_WAIT_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT_REQ: if (mac_req) state_d = ST_PRIME;
      ST_PRIME:    state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_RUN;
      ST_RUN: begin
        half_d = !half_q;
        // No read went out during half 0, so the word just shown was the last one.
        if (half_q && !rd_q) begin
          half_d  = 1'b0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (vld_cnt_q == fout_len_q) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue && ag_last_w && ag_last_o) rd_all_d = 1'b1;
    if (bias_rd_en) bsel_d = ag_o[2:0];
    if (rd_q) begin
      fin_buf_d = fin_rd_data;
      wgt_buf_d = wgt_rd_data;
    end
    if (brd_q) bias_d = bias_rd_data[{bsel_q, 5'd0} +: DW];
    if (fc_fout_vld && in_layer && (vld_cnt_q != fout_len_q)) vld_cnt_d = vld_cnt_q + LEN_W'(1);
  end

  assign rd_d  = issue;
  assign brd_d = bias_rd_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wpo_q      <= '0;
      fout_len_q <= '0;
      vld_cnt_q  <= '0;
      half_q     <= 1'b0;
      rd_q       <= 1'b0;
      brd_q      <= 1'b0;
      rd_all_q   <= 1'b0;
      err_q      <= 1'b0;
      bsel_q     <= '0;
      fin_buf_q  <= '0;
      wgt_buf_q  <= '0;
      bias_q     <= '0;
    end else begin
      state_q    <= state_d;
      wpo_q      <= wpo_d;
      fout_len_q <= fout_len_d;
      vld_cnt_q  <= vld_cnt_d;
      half_q     <= half_d;
      rd_q       <= rd_d;
      brd_q      <= brd_d;
      rd_all_q   <= rd_all_d;
      err_q      <= err_d;
      bsel_q     <= bsel_d;
      fin_buf_q  <= fin_buf_d;
      wgt_buf_q  <= wgt_buf_d;
      bias_q     <= bias_d;
    end
  end
endmodule

// File: tb/tb_fc_feed_sched.sv
// Bench for fc_feed_sched: RAM models plus queues of expected reads and lane values per cycle.
module tb_fc_feed_sched;
  import fc_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n, cfg_start, mac_req, fc_fout_vld;
  logic [LEN_W-1:0]   cfg_fin_div4_len, cfg_fout_len;
  logic [WGT_AW-1:0]  cfg_wgt_base;
  logic               busy, done, cfg_err, fc_calc_ing;
  logic               fin_rd_en, wgt_rd_en, bias_rd_en;
  logic [FIN_AW-1:0]  fin_rd_addr;
  logic [WGT_AW-1:0]  wgt_rd_addr;
  logic [BIAS_AW-1:0] bias_rd_addr;
  logic [WORD_W-1:0]  fin_rd_data, wgt_rd_data, bias_rd_data;
  logic [DW-1:0]      fc_fin_0, fc_fin_1, fc_fin_2, fc_fin_3;
  logic [DW-1:0]      fc_wgt_0, fc_wgt_1, fc_wgt_2, fc_wgt_3, fc_bias;

  int total = 0;
  int bad   = 0;

  logic [287:0] lane_sb[$];
  logic [34:0]  rd_sb[$];
  logic [8:0]   brd_sb[$];

  logic [287:0] act_lanes;
  logic [338:0] all_out;
  assign act_lanes = {fc_fin_3, fc_fin_2, fc_fin_1, fc_fin_0,
                      fc_wgt_3, fc_wgt_2, fc_wgt_1, fc_wgt_0, fc_bias};
  assign all_out = {busy, done, cfg_err, fin_rd_en, fin_rd_addr, wgt_rd_en, wgt_rd_addr,
                    bias_rd_en, bias_rd_addr, fc_calc_ing, act_lanes};

  fc_feed_sched dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_fin_div4_len(cfg_fin_div4_len), .cfg_fout_len(cfg_fout_len), .cfg_wgt_base(cfg_wgt_base),
    .busy(busy), .done(done), .cfg_err(cfg_err), .mac_req(mac_req), .fc_fout_vld(fc_fout_vld),
    .fin_rd_en(fin_rd_en), .fin_rd_addr(fin_rd_addr), .fin_rd_data(fin_rd_data),
    .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
    .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr), .bias_rd_data(bias_rd_data),
    .fc_calc_ing(fc_calc_ing),
    .fc_fin_0(fc_fin_0), .fc_fin_1(fc_fin_1), .fc_fin_2(fc_fin_2), .fc_fin_3(fc_fin_3),
    .fc_wgt_0(fc_wgt_0), .fc_wgt_1(fc_wgt_1), .fc_wgt_2(fc_wgt_2), .fc_wgt_3(fc_wgt_3),
    .fc_bias(fc_bias)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] fin_word(input logic [10:0] a);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = {8'hF0, 5'd0, a, 8'(j)};
    return r;
  endfunction

  function automatic logic [255:0] wgt_word(input logic [23:0] a);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = {4'hA, a, 4'(j)};
    return r;
  endfunction

  function automatic logic [255:0] bias_word(input logic [8:0] k);
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = {11'd0, k, 12'(j)};
    return r;
  endfunction

  function automatic logic [287:0] exp_lanes(input logic [10:0] w, input logic [23:0] wa,
                                             input int o, input int h);
    logic [255:0] fw, ww;
    logic [31:0]  b;
    fw = fin_word(w);
    ww = wgt_word(wa);
    b  = {11'd0, 9'(o / 8), 12'(o % 8)};
    return {fw[128*h +: 128], ww[128*h +: 128], b};
  endfunction

  always @(posedge clk) begin
    if (fin_rd_en)  fin_rd_data  <= fin_word(fin_rd_addr);
    if (wgt_rd_en)  wgt_rd_data  <= wgt_word(wgt_rd_addr);
    if (bias_rd_en) bias_rd_data <= bias_word(bias_rd_addr);
  end

  task automatic run_layer(input int fin4, input int fout, input logic [23:0] base,
                           input int req_delay, input int n_vld, input int restart_k);
    int wpo, exp_calc, budget, first_calc, last_calc, ncalc, pulses, last_pulse;
    int reach_k, drain_k, done_k, ndone, nerr, early, exp_done;
    logic [287:0] el;
    logic [34:0]  er;
    logic [8:0]   eb;
    wpo = fin4 / 2;
    exp_calc = 2 * wpo * fout;
    for (int o = 0; o < fout; o++) begin
      for (int w = 0; w < wpo; w++) begin
        logic [23:0] wa;
        wa = base + 24'(o * wpo + w);
        rd_sb.push_back({11'(w), wa});
        if (w == 0) brd_sb.push_back(9'(o / 8));
        for (int h = 0; h < 2; h++) lane_sb.push_back(exp_lanes(11'(w), wa, o, h));
      end
    end
    budget = req_delay + exp_calc + 2 * n_vld + 40;
    first_calc = -1; last_calc = -1; ncalc = 0; pulses = 0; last_pulse = -10;
    reach_k = -1; drain_k = -1; done_k = -1; ndone = 0; nerr = 0; early = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      cfg_start = (k == 0) || (restart_k > 0 && (k == restart_k || k == restart_k + 2));
      if (k == 0) begin
        cfg_fin_div4_len = 12'(fin4); cfg_fout_len = 12'(fout); cfg_wgt_base = base;
      end else if (k == restart_k) begin
        cfg_fin_div4_len = 12'd2; cfg_fout_len = 12'd1; cfg_wgt_base = 24'h0;
      end else if (k == restart_k + 2) begin
        cfg_fin_div4_len = 12'd0;
      end
      mac_req = (req_delay == 0) || (k > req_delay);
      fc_fout_vld = 1'b0;
      if (pulses < n_vld &&
          ((pulses == 0 && first_calc >= 0 && drain_k < 0) ||
           (pulses > 0 && drain_k >= 0 && k - last_pulse > 1))) begin
        fc_fout_vld = 1'b1;
        pulses++;
        last_pulse = k;
        if (pulses == fout) reach_k = k;
      end
      @(negedge clk);
      if (fc_calc_ing) begin
        if (first_calc < 0) first_calc = k;
        last_calc = k;
        ncalc++;
        total++;
        if (lane_sb.size() == 0) begin
          bad++; $display("FAIL lanes_extra k=%0d got calc=1 want calc=0", k);
        end else begin
          el = lane_sb.pop_front();
          if (act_lanes !== el) begin
            bad++; $display("FAIL lanes k=%0d got %h want %h", k, act_lanes, el);
          end
        end
      end else if (first_calc >= 0 && drain_k < 0) drain_k = k;
      if (fin_rd_en || wgt_rd_en) begin
        total++;
        if (rd_sb.size() == 0) begin
          bad++; $display("FAIL rd_extra k=%0d got fin=%h wgt=%h want no read", k, fin_rd_addr, wgt_rd_addr);
        end else begin
          er = rd_sb.pop_front();
          if ({fin_rd_en, wgt_rd_en, fin_rd_addr, wgt_rd_addr} !== {2'b11, er}) begin
            bad++; $display("FAIL rd_addr k=%0d got %b%b %h/%h want 11 %h/%h", k, fin_rd_en, wgt_rd_en,
                            fin_rd_addr, wgt_rd_addr, er[34:24], er[23:0]);
          end
        end
      end
      if (bias_rd_en) begin
        total++;
        if (brd_sb.size() == 0) begin
          bad++; $display("FAIL bias_rd_extra k=%0d got addr=%h want no read", k, bias_rd_addr);
        end else begin
          eb = brd_sb.pop_front();
          if (bias_rd_addr !== eb) begin
            bad++; $display("FAIL bias_rd_addr k=%0d got %h want %h", k, bias_rd_addr, eb);
          end
        end
      end
      if (k <= req_delay && (fin_rd_en || wgt_rd_en || bias_rd_en || fc_calc_ing)) early++;
      if (cfg_err) nerr++;
      if (k == 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_rise got %b want 1", busy); end
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k == done_k + 1) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL busy_fall got %b want 0", busy); end
        break;
      end
    end
    cfg_start = 1'b0; mac_req = 1'b0; fc_fout_vld = 1'b0;
    total++;
    if (first_calc != req_delay + 4) begin
      bad++; $display("FAIL calc_rise got k=%0d want k=%0d", first_calc, req_delay + 4);
    end
    total++;
    if (ncalc != exp_calc || last_calc - first_calc + 1 != exp_calc) begin
      bad++; $display("FAIL calc_len got %0d span %0d want %0d", ncalc, last_calc - first_calc + 1, exp_calc);
    end
    total++;
    if (lane_sb.size() + rd_sb.size() + brd_sb.size() != 0) begin
      bad++; $display("FAIL sb_left got %0d/%0d/%0d want 0/0/0", lane_sb.size(), rd_sb.size(), brd_sb.size());
    end
    lane_sb.delete(); rd_sb.delete(); brd_sb.delete();
    total++;
    if (early != 0 || nerr != 0) begin
      bad++; $display("FAIL idle_activity got early=%0d err=%0d want 0/0", early, nerr);
    end
    total++;
    if (n_vld >= fout) begin
      exp_done = (reach_k + 1 > drain_k) ? reach_k + 1 : drain_k;
      if (done_k != exp_done || ndone != 1) begin
        bad++; $display("FAIL done_time got k=%0d n=%0d want k=%0d n=1", done_k, ndone, exp_done);
      end
    end else if (ndone != 0 || busy !== 1'b1) begin
      bad++; $display("FAIL no_done got n=%0d busy=%b want n=0 busy=1", ndone, busy);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_start = 1'b0; mac_req = 1'b0; fc_fout_vld = 1'b0;
    cfg_fin_div4_len = '0; cfg_fout_len = '0; cfg_wgt_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got %h want 0", all_out); end
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL idle_outputs got %h want 0", all_out); end
  endtask

  task automatic test_basic();
    run_layer(4, 3, 24'h000100, 0, 3, 0);
  endtask

  task automatic test_bias();
    run_layer(2, 10, 24'h000040, 0, 10, 0);
  endtask

  task automatic test_mac_wait();
    run_layer(4, 3, 24'hFFFFFE, 20, 3, 0);
  endtask

  task automatic test_cfg_err();
    int fins[3] = '{5, 0, 4};
    int fouts[3] = '{3, 3, 0};
    for (int c = 0; c < 3; c++) begin
      int nerr, nbusy, nrd;
      logic err1;
      nerr = 0; nbusy = 0; nrd = 0; err1 = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        cfg_start = (k == 0);
        cfg_fin_div4_len = 12'(fins[c]); cfg_fout_len = 12'(fouts[c]); cfg_wgt_base = 24'h10;
        mac_req = 1'b1;
        @(negedge clk);
        if (cfg_err) nerr++;
        if (k == 1) err1 = cfg_err;
        if (busy) nbusy++;
        if (fin_rd_en || wgt_rd_en || bias_rd_en || fc_calc_ing) nrd++;
      end
      cfg_start = 1'b0; mac_req = 1'b0;
      total++;
      if (err1 !== 1'b1 || nerr != 1) begin
        bad++; $display("FAIL cfg_err case=%0d got k1=%b n=%0d want 1 n=1", c, err1, nerr);
      end
      total++;
      if (nbusy != 0 || nrd != 0) begin
        bad++; $display("FAIL cfg_err_idle case=%0d got busy=%0d rd=%0d want 0/0", c, nbusy, nrd);
      end
    end
    run_layer(4, 3, 24'h000100, 0, 3, 8);
  endtask

  task automatic test_no_done();
    run_layer(4, 3, 24'h000100, 0, 2, 0);
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    int ncalc, ndone, nbusy;
    ncalc = 0;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_fin_div4_len = 12'd4; cfg_fout_len = 12'd3; cfg_wgt_base = 24'h100;
    mac_req = 1'b1;
    for (int k = 0; k < 40 && ncalc < 5; k++) begin
      @(negedge clk);
      if (fc_calc_ing) ncalc++;
      @(posedge clk); #1;
      cfg_start = 1'b0;
    end
    total++;
    if (ncalc != 5) begin bad++; $display("FAIL mid_run_timeout got calc=%0d want 5", ncalc); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mac_req = 1'b0;
    @(negedge clk);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL mid_reset_outputs got %h want 0", all_out); end
    ndone = 0; nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      fc_fout_vld = (k % 3 == 0);
      @(negedge clk);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    fc_fout_vld = 1'b0;
    total++;
    if (ndone != 0 || nbusy != 0) begin
      bad++; $display("FAIL mid_reset_quiet got done=%0d busy=%0d want 0/0", ndone, nbusy);
    end
    run_layer(4, 3, 24'h000100, 0, 3, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_bias();
    test_mac_wait();
    test_cfg_err();
    test_no_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
